// File: rtl/mult_share_arbiter_v.sv
// mult_share_arbiter_v
//   Round-robin front end that shares one 4x4 unsigned multiplier between
//   two requesters. One operand pair is accepted at a time over a
//   valid/ready handshake and held in operand registers. The product is
//   captured after MUL_CYCLES cycles and returned as two nibbles over a
//   second valid/ready handshake to the requester that was granted.
//
// Ports
//   i_clk, i_rst_n               clock, async active-low reset
//   i_reqK_valid / o_reqK_ready  operand handshake of requester K
//   i_reqK_au, i_reqK_bu         4-bit unsigned operands of requester K
//   o_rspK_valid / i_rspK_ready  result handshake of requester K
//   o_fu0, o_fu1                 product[3:0], product[7:4] (shared)
//   o_busy                       operation in flight (MUL or RESP)
//   o_grant_id                   requester currently/last granted
module mult_share_arbiter_v #(
  parameter int unsigned MUL_CYCLES = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req0_valid,
  input  logic       i_req1_valid,
  output logic       o_req0_ready,
  output logic       o_req1_ready,
  input  logic [3:0] i_req0_au,
  input  logic [3:0] i_req0_bu,
  input  logic [3:0] i_req1_au,
  input  logic [3:0] i_req1_bu,
  output logic       o_rsp0_valid,
  output logic       o_rsp1_valid,
  input  logic       i_rsp0_ready,
  input  logic       i_rsp1_ready,
  output logic [3:0] o_fu0,
  output logic [3:0] o_fu1,
  output logic       o_busy,
  output logic       o_grant_id
);

  localparam logic [3:0] MC = 4'(MUL_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_RESP} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       prio_q, prio_d;
  logic       gid_q, gid_d;
  logic [3:0] au_q, au_d, bu_q, bu_d;
  logic [7:0] fu_q, fu_d;

  logic       gnt;      // requester selected by the arbiter this cycle
  logic       acc;      // operand handshake completes at the next edge
  logic       rsp_hs;   // result handshake of the granted requester
  logic [7:0] prod;

  // With both valid the pointer decides; otherwise whichever is valid.
  assign gnt    = (i_req0_valid && i_req1_valid) ? prio_q : i_req1_valid;
  // Reset gates the handshake so ready never shows while in reset.
  assign acc    = i_rst_n && (state_q == S_IDLE) &&
                  (gnt ? i_req1_valid : i_req0_valid);
  assign rsp_hs = gid_q ? i_rsp1_ready : i_rsp0_ready;
  assign prod   = {4'b0, au_q} * {4'b0, bu_q};

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prio_q  <= 1'b0;
      gid_q   <= 1'b0;
      au_q    <= '0;
      bu_q    <= '0;
      fu_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      gid_q   <= gid_d;
      au_q    <= au_d;
      bu_q    <= bu_d;
      fu_q    <= fu_d;
    end
  end

  // Next state and datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    gid_d   = gid_q;
    au_d    = au_q;
    bu_d    = bu_q;
    fu_d    = fu_q;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          state_d = S_MUL;
          cnt_d   = MC;
          gid_d   = gnt;
          prio_d  = ~gnt;
          au_d    = gnt ? i_req1_au : i_req0_au;
          bu_d    = gnt ? i_req1_bu : i_req0_bu;
        end
      end
      S_MUL: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          fu_d    = prod;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    o_req0_ready = acc && !gnt;
    o_req1_ready = acc && gnt;
    o_rsp0_valid = (state_q == S_RESP) && !gid_q;
    o_rsp1_valid = (state_q == S_RESP) && gid_q;
    o_busy       = (state_q != S_IDLE);
    o_grant_id   = gid_q;
    o_fu0        = fu_q[3:0];
    o_fu1        = fu_q[7:4];
  end

endmodule

// File: tb/tb_mult_share_arbiter_v.sv
// Testbench for mult_share_arbiter_v. Two instances run side by side:
// index 0 uses MUL_CYCLES=1, index 1 uses MUL_CYCLES=3. Expected grants,
// products, latencies and throughput come from a transaction-level model.
module tb_mult_share_arbiter_v;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]       rst_n, v0, v1, rr0, rr1;
  logic [1:0][3:0]  a0, b0, a1, b1;
  logic [1:0]       rdy0, rdy1, rv0, rv1, busy, gid;
  logic [1:0][3:0]  fu0, fu1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mult_share_arbiter_v #(.MUL_CYCLES(g ? 3 : 1)) u_dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n[g]),
      .i_req0_valid (v0[g]),
      .i_req1_valid (v1[g]),
      .o_req0_ready (rdy0[g]),
      .o_req1_ready (rdy1[g]),
      .i_req0_au    (a0[g]),
      .i_req0_bu    (b0[g]),
      .i_req1_au    (a1[g]),
      .i_req1_bu    (b1[g]),
      .o_rsp0_valid (rv0[g]),
      .o_rsp1_valid (rv1[g]),
      .i_rsp0_ready (rr0[g]),
      .i_rsp1_ready (rr1[g]),
      .o_fu0        (fu0[g]),
      .o_fu1        (fu1[g]),
      .o_busy       (busy[g]),
      .o_grant_id   (gid[g])
    );
  end

  int errors = 0;
  int checks = 0;
  int prio_m [2];
  int last_acc [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mc(input int d);
    return d ? 3 : 1;
  endfunction

  // One complete transaction on instance d. Called at posedge+1.
  task automatic run_op(input int d, input bit w0, input bit w1,
                        input logic [3:0] x0, input logic [3:0] y0,
                        input logic [3:0] x1, input logic [3:0] y1,
                        input int bp, input bit thru);
    int g, lat;
    int exp;
    g = (w0 && w1) ? prio_m[d] : (w1 ? 1 : 0);
    exp = (g == 1) ? int'(x1) * int'(y1) : int'(x0) * int'(y0);
    v0[d] = w0; v1[d] = w1;
    a0[d] = x0; b0[d] = y0; a1[d] = x1; b1[d] = y1;
    // granted requester's rsp ready follows backpressure; the other is
    // held high to show it is ignored
    rr0[d] = (g == 0) ? (bp == 0) : 1'b1;
    rr1[d] = (g == 1) ? (bp == 0) : 1'b1;
    #1;
    chk("idle_rdy0", 32'(rdy0[d]), 32'(w0 && g == 0));
    chk("idle_rdy1", 32'(rdy1[d]), 32'(w1 && g == 1));
    chk("idle_busy", 32'(busy[d]), 32'd0);
    @(posedge clk); #1;
    if (thru && last_acc[d] >= 0) chk("period", 32'(cyc - last_acc[d]), 32'(mc(d) + 2));
    last_acc[d] = cyc;
    prio_m[d] = 1 - g;
    // operands after accept must not matter
    a0[d] = 4'($urandom); b0[d] = 4'($urandom);
    a1[d] = 4'($urandom); b1[d] = 4'($urandom);
    lat = 1;
    while (!(g ? rv1[d] : rv0[d]) && lat < 40) begin
      chk("mul_busy", 32'(busy[d]), 32'd1);
      chk("mul_rdy", 32'({rdy1[d], rdy0[d]}), 32'd0);
      chk("mul_rv_other", 32'(g ? rv0[d] : rv1[d]), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(mc(d) + 1));
    chk("fu1", 32'(fu1[d]), 32'(exp >> 4));
    chk("fu0", 32'(fu0[d]), 32'(exp & 15));
    chk("grant_id", 32'(gid[d]), 32'(g));
    chk("rv_other", 32'(g ? rv0[d] : rv1[d]), 32'd0);
    chk("resp_rdy", 32'({rdy1[d], rdy0[d]}), 32'd0);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("bp_rv", 32'(g ? rv1[d] : rv0[d]), 32'd1);
      chk("bp_fu", 32'({fu1[d], fu0[d]}), 32'(exp));
      chk("bp_rdy", 32'({rdy1[d], rdy0[d]}), 32'd0);
    end
    if (g == 1) rr1[d] = 1'b1; else rr0[d] = 1'b1;
    @(posedge clk); #1;
    chk("post_busy", 32'(busy[d]), 32'd0);
    chk("post_rv", 32'({rv1[d], rv0[d]}), 32'd0);
    chk("post_fu", 32'({fu1[d], fu0[d]}), 32'(exp));
    v0[d] = 1'b0; v1[d] = 1'b0;
  endtask

  initial begin
    rst_n = '0; v0 = '1; v1 = '1; rr0 = '0; rr1 = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    prio_m = '{0, 0};
    last_acc = '{-1, -1};
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdy", 32'({rdy1[d], rdy0[d]}), 32'd0);
      chk("rst_rv", 32'({rv1[d], rv0[d]}), 32'd0);
      chk("rst_fu", 32'({fu1[d], fu0[d]}), 32'd0);
      chk("rst_busy_gid", 32'({busy[d], gid[d]}), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = '1; v0 = '0; v1 = '0;

    // maximum product, single requester
    run_op(0, 1, 0, 4'd15, 4'd15, 4'd0, 4'd0, 0, 0);
    // simultaneous first requests: req0 then req1
    run_op(1, 1, 1, 4'd3, 4'd5, 4'd7, 4'd9, 0, 0);
    run_op(1, 1, 1, 4'd3, 4'd5, 4'd7, 4'd9, 0, 0);
    // operand change after accept, MUL_CYCLES=3
    run_op(1, 0, 1, 4'd0, 4'd0, 4'd12, 4'd11, 0, 0);
    // backpressure with the other requester pending
    run_op(0, 1, 1, 4'd2, 4'd3, 4'd4, 4'd5, 0, 0);
    run_op(0, 1, 1, 4'd6, 4'd7, 4'd8, 4'd9, 5, 0);
    run_op(0, 1, 1, 4'd1, 4'd1, 4'd13, 4'd14, 0, 0);
    // fairness and throughput on both instances
    for (int d = 0; d < 2; d++) begin
      last_acc[d] = -1;
      for (int k = 0; k < 4; k++)
        run_op(d, 1, 1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 0, 1);
    end

    // reset in the middle of MUL abandons the operation
    v1[1] = 1'b1; a1[1] = 4'd9; b1[1] = 4'd9; rr0[1] = 1'b1; rr1[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n[1] = 1'b0; v0[1] = 1'b1;
    #1;
    chk("arst_rdy", 32'({rdy1[1], rdy0[1]}), 32'd0);
    chk("arst_rv", 32'({rv1[1], rv0[1]}), 32'd0);
    chk("arst_fu", 32'({fu1[1], fu0[1]}), 32'd0);
    chk("arst_busy_gid", 32'({busy[1], gid[1]}), 32'd0);
    @(posedge clk); #1;
    chk("arst_hold_rdy", 32'({rdy1[1], rdy0[1]}), 32'd0);
    rst_n[1] = 1'b1;
    prio_m[1] = 0;
    run_op(1, 1, 1, 4'd10, 4'd6, 4'd9, 4'd9, 0, 0);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      int d, p;
      bit w0, w1;
      d = k & 1;
      p = int'($urandom_range(2, 0));
      w0 = 1'($urandom); w1 = 1'($urandom);
      if (!w0 && !w1) w0 = 1'b1;
      run_op(d, w0, w1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), p, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
